// File: rtl/xm23_clock_ctrl.sv
// XM23 core clock controller: divides the board clock in RUN mode, holds it in HALT,
// and issues single debounced steps from a push button in STEP mode.
module xm23_clock_ctrl #(
    parameter int CNT_W           = 32,
    parameter int DIV_DEFAULT     = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int DB_W            = 20
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] div_half,
    input  logic             div_load,
    input  logic             step_btn,
    output logic             clock,
    output logic             cpu_en,
    output logic [CNT_W-1:0] cycle_count,
    output logic             running,
    output logic             led
);

    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_ONE   = DB_W'(1);
    localparam logic [1:0]       MODE_RUN  = 2'b01;
    localparam logic [1:0]       MODE_STEP = 2'b10;

    typedef enum logic [1:0] {
        HALTED    = 2'd0,
        RUNNING   = 2'd1,
        STEP_HIGH = 2'd2,
        STEP_LOW  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              db_level_q, db_level_d;
    logic              step_req_q, step_req_d;
    logic [CNT_W-1:0]  div_q, div_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              clock_q, clock_d;
    logic              cpu_en_q, cpu_en_d;
    logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
    logic              led_q, led_d;
    logic              running_q, running_d;
    logic              terminal;
    logic              rise;

    // div_q is never zero, so div_q - 1 cannot underflow.
    assign terminal = (cnt_q >= (div_q - ONE));

    always_comb begin
        state_d       = state_q;
        sync1_d       = step_btn;
        sync2_d       = sync1_q;
        db_cnt_d      = db_cnt_q;
        db_level_d    = db_level_q;
        div_d         = div_q;
        cnt_d         = cnt_q;
        clock_d       = clock_q;
        cpu_en_d      = 1'b0;
        cycle_count_d = cycle_count_q;
        led_d         = led_q;
        rise          = 1'b0;

        if (sync2_q == db_level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            db_level_d = sync2_q;
            db_cnt_d   = '0;
        end else begin
            db_cnt_d = db_cnt_q + DB_ONE;
        end
        step_req_d = db_level_d & ~db_level_q;

        if (div_load) begin
            div_d = (div_half == '0) ? DIV_INIT : div_half;
        end

        case (state_q)
            HALTED: begin
                clock_d = 1'b0;
                cnt_d   = '0;
                if (mode == MODE_RUN) begin
                    state_d = RUNNING;
                end else if (mode == MODE_STEP && step_req_q) begin
                    state_d = STEP_HIGH;
                    rise    = 1'b1;
                end
            end
            RUNNING: begin
                if (terminal) begin
                    cnt_d = '0;
                    // Mode is only honoured at the end of a low phase so a high phase always completes.
                    if (clock_q) begin
                        clock_d = 1'b0;
                    end else if (mode == MODE_RUN) begin
                        rise = 1'b1;
                    end else begin
                        state_d = HALTED;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            STEP_HIGH: begin
                if (terminal) begin
                    cnt_d   = '0;
                    clock_d = 1'b0;
                    state_d = STEP_LOW;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                if (terminal) begin
                    cnt_d   = '0;
                    state_d = HALTED;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
        endcase

        if (rise) begin
            clock_d       = 1'b1;
            cpu_en_d      = 1'b1;
            cycle_count_d = cycle_count_q + ONE;
            led_d         = ~led_q;
        end

        running_d = (state_d == RUNNING);
    end

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            state_q       <= HALTED;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            db_cnt_q      <= '0;
            db_level_q    <= 1'b0;
            step_req_q    <= 1'b0;
            div_q         <= DIV_INIT;
            cnt_q         <= '0;
            clock_q       <= 1'b0;
            cpu_en_q      <= 1'b0;
            cycle_count_q <= '0;
            led_q         <= 1'b0;
            running_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            db_cnt_q      <= db_cnt_d;
            db_level_q    <= db_level_d;
            step_req_q    <= step_req_d;
            div_q         <= div_d;
            cnt_q         <= cnt_d;
            clock_q       <= clock_d;
            cpu_en_q      <= cpu_en_d;
            cycle_count_q <= cycle_count_d;
            led_q         <= led_d;
            running_q     <= running_d;
        end
    end

    assign clock       = clock_q;
    assign cpu_en      = cpu_en_q;
    assign cycle_count = cycle_count_q;
    assign running     = running_q;
    assign led         = led_q;

endmodule

// File: tb/tb_xm23_clock_ctrl.sv
// Bench for xm23_clock_ctrl: a phase-level model is compared every cycle,
// and directed sequences pin hand-computed values.
module tb_xm23_clock_ctrl;

    localparam int CNT_W   = 8;
    localparam int DIV_DEF = 4;
    localparam int DEBC    = 3;
    localparam int DB_W    = 4;

    logic             clock_in = 1'b0;
    logic             reset    = 1'b0;
    logic [1:0]       mode     = 2'b00;
    logic [CNT_W-1:0] div_half = '0;
    logic             div_load = 1'b0;
    logic             step_btn = 1'b0;
    logic             clock;
    logic             cpu_en;
    logic [CNT_W-1:0] cycle_count;
    logic             running;
    logic             led;

    int checks = 0;
    int errors = 0;

    xm23_clock_ctrl #(
        .CNT_W(CNT_W),
        .DIV_DEFAULT(DIV_DEF),
        .DEBOUNCE_CYCLES(DEBC),
        .DB_W(DB_W)
    ) dut (
        .clock_in(clock_in),
        .reset(reset),
        .mode(mode),
        .div_half(div_half),
        .div_load(div_load),
        .step_btn(step_btn),
        .clock(clock),
        .cpu_en(cpu_en),
        .cycle_count(cycle_count),
        .running(running),
        .led(led)
    );

    always #5 clock_in = ~clock_in;

    // Model: phase 0 idle, 1 free run, 2 step high, 3 step low; age = cycles spent in current phase.
    int               m_phase = 0;
    int               m_age   = 0;
    int               m_div   = DIV_DEF;
    bit               m_clk   = 1'b0;
    bit               m_en    = 1'b0;
    bit               m_led   = 1'b0;
    bit               m_req   = 1'b0;
    bit               m_level = 1'b0;
    logic [CNT_W-1:0] m_count = '0;
    bit               btn_hist[$];
    bit               seen_hist[$];

    always @(posedge clock_in or negedge reset) begin
        bit s;
        bit accept;
        bit rise;
        bit fin;
        if (!reset) begin
            m_phase = 0; m_age = 0; m_div = DIV_DEF;
            m_clk = 0; m_en = 0; m_led = 0; m_req = 0; m_level = 0; m_count = '0;
            btn_hist.delete();
            seen_hist.delete();
        end else begin
            // The debouncer sees the button as it was two edges ago.
            btn_hist.push_back(step_btn);
            if (btn_hist.size() > 3) void'(btn_hist.pop_front());
            s = (btn_hist.size() == 3) ? btn_hist[0] : 1'b0;
            seen_hist.push_back(s);
            if (seen_hist.size() > DEBC) void'(seen_hist.pop_front());
            accept = (seen_hist.size() == DEBC);
            foreach (seen_hist[i]) if (seen_hist[i] == m_level) accept = 1'b0;

            rise = 1'b0;
            fin  = (m_age + 1 >= m_div);
            case (m_phase)
                0: begin
                    m_age = 0;
                    if (mode == 2'b01) m_phase = 1;
                    else if (mode == 2'b10 && m_req) begin m_phase = 2; rise = 1'b1; end
                end
                1: begin
                    if (!fin) m_age++;
                    else begin
                        m_age = 0;
                        if (m_clk) m_clk = 1'b0;
                        else if (mode == 2'b01) rise = 1'b1;
                        else m_phase = 0;
                    end
                end
                2: if (!fin) m_age++; else begin m_age = 0; m_clk = 1'b0; m_phase = 3; end
                default: if (!fin) m_age++; else begin m_age = 0; m_phase = 0; end
            endcase
            m_en = rise;
            if (rise) begin m_clk = 1'b1; m_count = m_count + 1'b1; m_led = !m_led; end

            m_req = accept && !m_level;
            if (accept) m_level = !m_level;
            if (div_load) m_div = (div_half == 0) ? DIV_DEF : int'(div_half);
        end
    end

    always @(negedge clock_in) begin
        checks++;
        if (clock !== m_clk || cpu_en !== m_en || cycle_count !== m_count ||
            running !== (m_phase == 1) || led !== m_led) begin
            errors++;
            $display("FAIL model_cycle t=%0t: dut clk=%b en=%b cnt=%0d run=%b led=%b, model clk=%b en=%b cnt=%0d run=%b led=%b",
                     $time, clock, cpu_en, cycle_count, running, led,
                     m_clk, m_en, m_count, (m_phase == 1), m_led);
        end
    end

    task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock_in);
    endtask

    task automatic load(input int v);
        div_half = CNT_W'(v);
        div_load = 1'b1;
        tick(1);
        div_load = 1'b0;
    endtask

    logic [CNT_W-1:0] frozen;
    bit               c0;
    bit               found;

    initial begin
        #3;
        pin("reset clock", clock, 0);
        pin("reset cpu_en", cpu_en, 0);
        pin("reset count", cycle_count, 0);
        pin("reset running", running, 0);
        pin("reset led", led, 0);
        tick(2);
        reset = 1'b1; mode = 2'b01;

        tick(1); pin("run entry running", running, 1); pin("run entry clock", clock, 0);
        tick(3); pin("pre-rise clock", clock, 0);
        tick(1); pin("rise1 clock", clock, 1); pin("rise1 cpu_en", cpu_en, 1);
                 pin("rise1 count", cycle_count, 1); pin("rise1 led", led, 1);
        tick(1); pin("rise1+1 cpu_en", cpu_en, 0);
        tick(2); pin("high end clock", clock, 1);
        tick(1); pin("fall clock", clock, 0);
        tick(4); pin("rise2 count", cycle_count, 2); pin("rise2 cpu_en", cpu_en, 1); pin("rise2 led", led, 0);
        tick(8); pin("rise3 count", cycle_count, 3);

        load(1);
        tick(2); pin("div1 rise cpu_en", cpu_en, 1); pin("div1 rise count", cycle_count, 4);
        tick(1); pin("div1 fall cpu_en", cpu_en, 0); pin("div1 fall clock", clock, 0);
        tick(1); pin("div1 rise2 count", cycle_count, 5);
        load(0);
        tick(4); pin("div0 restore count", cycle_count, 6); pin("div0 restore cpu_en", cpu_en, 1);

        // Shrink the half-period while the counter is already past the new terminal value.
        load(8);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_phase == 1 && m_age == 3) found = 1; else tick(1);
        end
        pin("shrink reach count3", found, 1);
        c0 = m_clk;
        load(2); pin("shrink no early toggle", clock, c0);
        tick(1); pin("shrink toggle", clock, !c0);
        load(0);

        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin tick(1); if (cpu_en === 1'b1) found = 1; end
        pin("halt wait rise", found, 1);
        mode = 2'b00;
        frozen = m_count;
        tick(3); pin("halt high kept", clock, 1);
        tick(1); pin("halt fall", clock, 0); pin("halt still running", running, 1);
        tick(3); pin("halt low kept", running, 1);
        tick(1); pin("halt entered", running, 0);
        tick(20); pin("halt frozen count", cycle_count, frozen); pin("halt clock", clock, 0);

        mode = 2'b10;
        load(16);
        step_btn = 1'b1; tick(2); step_btn = 1'b0;
        tick(12); pin("glitch no step", cycle_count, frozen); pin("glitch clock", clock, 0);
        step_btn = 1'b1;
        tick(5); pin("step pre-rise", clock, 0);
        tick(1); pin("step rise clock", clock, 1); pin("step cpu_en", cpu_en, 1);
                 pin("step count", cycle_count, frozen + 8'd1);
        tick(4); step_btn = 1'b0;
        tick(4); step_btn = 1'b1;
        tick(6); step_btn = 1'b0; pin("second press high", clock, 1);
        tick(4); pin("step low", clock, 0);
        tick(20); pin("step single count", cycle_count, frozen + 8'd1);
        pin("step back halted", running, 0); pin("step halted clock", clock, 0);

        mode = 2'b01;
        load(1);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin tick(1); if (clock === 1'b1) found = 1; end
        pin("reset wait high", found, 1);
        #2 reset = 1'b0;
        #1;
        pin("async clock", clock, 0); pin("async cpu_en", cpu_en, 0); pin("async running", running, 0);
        pin("async led", led, 0); pin("async count", cycle_count, 0);
        @(negedge clock_in); reset = 1'b1;
        tick(1); pin("post-reset running", running, 1); pin("post-reset clock", clock, 0);
        tick(4); pin("post-reset div4 rise", clock, 1); pin("post-reset count", cycle_count, 1);

        load(1);
        found = 0;
        for (int i = 0; i < 700 && !found; i++) begin
            tick(1);
            if (cycle_count === 8'd255 && cpu_en === 1'b1) found = 1;
        end
        pin("wrap reach 255", found, 1);
        tick(2); pin("wrap to 0", cycle_count, 0); pin("wrap cpu_en", cpu_en, 1);
        tick(2); pin("wrap to 1", cycle_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion, expected summary before 100000 ns");
        $fatal(1, "timeout");
    end

endmodule
